regfile_writeback_ctrl: RTL and testbench

//  Initiator side of the register-file write port. Accepts writeback requests from the datapath over a

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_fifo.sv | 94 +++++++++
 rtl/regfile_writeback_ctrl.sv | 105 ++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the writeback entry type for the register-file write port.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Writeback request FIFO: storage, pointers, occupancy, tail-data overwrite and
// parallel address compares over the live entries for the pending flags.
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          overwrite,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] tail_addr,
    output logic [LW-1:0] level,
    output logic          full,
    input  logic [AW-1:0] query_addr1,
    input  logic [AW-1:0] query_addr2,
    output logic          match1,
    output logic          match2
);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic [PW-1:0]    offset;

    assign full     = (count == LW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && (count != '0);
    assign tail_ptr = wr_ptr - PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries outside [rd_ptr, rd_ptr+count) are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end else if (overwrite && (count != '0)) begin
            data_mem[tail_ptr] <= push_data;
        end
    end

    always_comb begin
        offset      = '0;
        entry_valid = '0;
        hit1        = '0;
        hit2        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
            hit1[i]        = entry_valid[i] && (addr_mem[i] == query_addr1);
            hit2[i]        = entry_valid[i] && (addr_mem[i] == query_addr2);
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign tail_addr = addr_mem[tail_ptr];
    assign level     = count;
    assign match1    = |hit1;
    assign match2    = |hit2;

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback controller: handshake, FIFO buffering, registered drain and
// pending-write status. Define REGWB_COALESCE_EN to merge requests hitting the tail register.
module regfile_writeback_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WbValid,
    output logic          WbReady,
    input  logic [AW-1:0] WbRegister,
    input  logic [DW-1:0] WbData,
    input  logic          WbStall,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData,
    output logic          RegWrite,
    input  logic [AW-1:0] QueryRegister1,
    input  logic [AW-1:0] QueryRegister2,
    output logic          Pending1,
    output logic          Pending2,
    output logic [LW-1:0] Level
);

`ifdef REGWB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [AW-1:0] tail_addr;
    logic          fifo_match1;
    logic          fifo_match2;
    logic          pop;
    logic          push;
    logic          overwrite;
    logic          accept;
    logic          nonzero;
    logic          coalesce_hit;

    assign pop = !WbStall && (fifo_level != '0);

    // A single-entry FIFO being popped cannot be overwritten; the request becomes a new entry.
    assign coalesce_hit = COALESCE && (WbRegister == tail_addr) &&
                          ((fifo_level >= LW'(2)) || ((fifo_level == LW'(1)) && !pop));

    assign WbReady   = !Reset && (!fifo_full || (WbValid && coalesce_hit));
    assign accept    = WbValid && WbReady;
    assign nonzero   = (WbRegister != AW'(ZERO_REG));
    assign push      = accept && nonzero && !coalesce_hit;
    assign overwrite = accept && nonzero && coalesce_hit;

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (Clk),
        .rst         (Reset),
        .push        (push),
        .push_addr   (WbRegister),
        .push_data   (WbData),
        .overwrite   (overwrite),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .tail_addr   (tail_addr),
        .level       (fifo_level),
        .full        (fifo_full),
        .query_addr1 (QueryRegister1),
        .query_addr2 (QueryRegister2),
        .match1      (fifo_match1),
        .match2      (fifo_match2)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (pop) begin
            RegWrite      <= 1'b1;
            WriteRegister <= head_addr;
            WriteData     <= head_data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // The write sitting in the output stage still counts as pending until its commit edge.
    assign Pending1 = !Reset && (QueryRegister1 != AW'(ZERO_REG)) &&
                      (fifo_match1 || (RegWrite && (WriteRegister == QueryRegister1)));
    assign Pending2 = !Reset && (QueryRegister2 != AW'(ZERO_REG)) &&
                      (fifo_match2 || (RegWrite && (WriteRegister == QueryRegister2)));

    assign Level = fifo_level;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl; directed vectors, commits checked by a monitor.
module tb_regfile_writeback_ctrl;
    import regfile_pkg::*;

`ifdef REGWB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        WbValid;
    logic        WbReady;
    logic [4:0]  WbRegister;
    logic [31:0] WbData;
    logic        WbStall;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  QueryRegister1;
    logic [4:0]  QueryRegister2;
    logic        Pending1;
    logic        Pending2;
    logic [2:0]  Level;

    wb_entry_t expQ[$];
    int checks   = 0;
    int failures = 0;

    regfile_writeback_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .WbValid        (WbValid),
        .WbReady        (WbReady),
        .WbRegister     (WbRegister),
        .WbData         (WbData),
        .WbStall        (WbStall),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .RegWrite       (RegWrite),
        .QueryRegister1 (QueryRegister1),
        .QueryRegister2 (QueryRegister2),
        .Pending1       (Pending1),
        .Pending2       (Pending2),
        .Level          (Level)
    );

    initial forever #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] wreg, input logic [31:0] data,
                                 input logic stall);
        WbValid    = valid;
        WbRegister = wreg;
        WbData     = data;
        WbStall    = stall;
    endtask

    task automatic expectPush(input logic [4:0] addr, input logic [31:0] data);
        wb_entry_t e;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Every commit must match the oldest outstanding expected write.
    always @(negedge Clk) begin
        if (RegWrite) begin
            checkOutput("commit_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                wb_entry_t e;
                e = expQ.pop_front();
                checkOutput("commit_reg", 32'(WriteRegister), 32'(e.addr));
                checkOutput("commit_data", WriteData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench still running at 200000, expected to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        Reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        QueryRegister1 = 5'd2;
        QueryRegister2 = 5'd0;
        #2;
        checkOutput("reset_ready", 32'(WbReady), 32'd0);
        checkOutput("reset_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("reset_level", 32'(Level), 32'd0);
        checkOutput("reset_wreg", 32'(WriteRegister), 32'd0);
        checkOutput("reset_wdata", WriteData, 32'd0);
        checkOutput("reset_pending1", 32'(Pending1), 32'd0);
        step();
        step();
        Reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(WbReady), 32'd1);

        // Single write with pending tracking
        applyStimulus(1'b1, 5'd2, 32'd42, 1'b0);
        #1;
        checkOutput("t1_ready", 32'(WbReady), 32'd1);
        checkOutput("t1_pending_before", 32'(Pending1), 32'd0);
        expectPush(5'd2, 32'd42);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        checkOutput("t1_level", 32'(Level), 32'd1);
        checkOutput("t1_regwrite_queued", 32'(RegWrite), 32'd0);
        checkOutput("t1_pending_queued", 32'(Pending1), 32'd1);
        step();
        checkOutput("t1_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("t1_wreg", 32'(WriteRegister), 32'd2);
        checkOutput("t1_wdata", WriteData, 32'd42);
        checkOutput("t1_pending_inflight", 32'(Pending1), 32'd1);
        step();
        checkOutput("t1_regwrite_off", 32'(RegWrite), 32'd0);
        checkOutput("t1_pending_clear", 32'(Pending1), 32'd0);

        // Stall fill: five offered, four accepted
        QueryRegister2 = 5'd5;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 5'(3 + k), 32'(100 + k), 1'b1);
            #1;
            checkOutput("t2_ready", 32'(WbReady), 32'(k < 4));
            if (k < 4) expectPush(5'(3 + k), 32'(100 + k));
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("t2_level", 32'(Level), 32'd4);
        checkOutput("t2_regwrite_stalled", 32'(RegWrite), 32'd0);
        checkOutput("t2_pending2", 32'(Pending2), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("t2_drain_regwrite", 32'(RegWrite), 32'd1);
            checkOutput("t2_drain_reg", 32'(WriteRegister), 32'(3 + k));
        end
        step();
        checkOutput("t2_idle", 32'(RegWrite), 32'd0);
        checkOutput("t2_pending2_clear", 32'(Pending2), 32'd0);

        // Register zero is accepted and discarded
        QueryRegister1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'd4, 1'b0);
        #1;
        checkOutput("t3_ready", 32'(WbReady), 32'd1);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t3_level", 32'(Level), 32'd0);
        checkOutput("t3_pending", 32'(Pending1), 32'd0);
        step();
        checkOutput("t3_regwrite", 32'(RegWrite), 32'd0);

        // Same-register ordering (merged when coalescing)
        applyStimulus(1'b1, 5'd17, 32'd12, 1'b1);
        #1;
        checkOutput("t4_ready_a", 32'(WbReady), 32'd1);
        expectPush(5'd17, 32'd12);
        step();
        applyStimulus(1'b1, 5'd17, 32'd15, 1'b1);
        #1;
        checkOutput("t4_ready_b", 32'(WbReady), 32'd1);
        if (COAL) begin
            wb_entry_t e;
            e = expQ.pop_back();
            e.data = 32'd15;
            expQ.push_back(e);
        end else begin
            expectPush(5'd17, 32'd15);
        end
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("t4_level", 32'(Level), COAL ? 32'd1 : 32'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        checkOutput("t4_first_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("t4_first_data", WriteData, COAL ? 32'd15 : 32'd12);
        step();
        checkOutput("t4_second_regwrite", 32'(RegWrite), COAL ? 32'd0 : 32'd1);
        checkOutput("t4_last_data", WriteData, 32'd15);
        step();
        checkOutput("t4_idle", 32'(RegWrite), 32'd0);

        // Reset in the middle of a drain
        QueryRegister1 = 5'd9;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'(8 + k), 32'(200 + k), 1'b1);
            #1;
            expectPush(5'(8 + k), 32'(200 + k));
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("t5_level", 32'(Level), 32'd3);
        checkOutput("t5_pending_pre", 32'(Pending1), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        checkOutput("t5_regwrite_pre", 32'(RegWrite), 32'd1);
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        checkOutput("t5_regwrite_reset", 32'(RegWrite), 32'd0);
        checkOutput("t5_level_reset", 32'(Level), 32'd0);
        checkOutput("t5_pending_reset", 32'(Pending1), 32'd0);
        checkOutput("t5_ready_reset", 32'(WbReady), 32'd0);
        expQ.delete();
        step();
        step();
        Reset = 1'b0;
        step();
        step();
        checkOutput("t5_no_stale", 32'(RegWrite), 32'd0);
        checkOutput("t5_level_after", 32'(Level), 32'd0);

        // Full FIFO with drain running and requests held
        QueryRegister1 = 5'd0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'(11 + k), 32'(300 + k), 1'b1);
            #1;
            expectPush(5'(11 + k), 32'(300 + k));
            step();
        end
        idx = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            applyStimulus(1'b1, 5'(20 + idx), 32'(400 + idx), 1'b0);
            #1;
            checkOutput("t6_ready", 32'(WbReady), 32'(cyc != 0));
            checkOutput("t6_level", 32'(Level), (cyc == 0) ? 32'd4 : 32'd3);
            if (cyc != 0) begin
                expectPush(5'(20 + idx), 32'(400 + idx));
                idx++;
            end
            step();
            checkOutput("t6_regwrite", 32'(RegWrite), 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        checkOutput("final_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("final_level", 32'(Level), 32'd0);
        checkOutput("final_scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
